// File: rtl/shift_counter_pkg.sv
// Shared mode encodings and sizing helper for the shift counter generator.
// Reserved mode 2'b11 behaves exactly like MODE_HOLD.
package shift_counter_pkg;

    localparam logic [1:0] MODE_JOHNSON = 2'b00;
    localparam logic [1:0] MODE_RING    = 2'b01;
    localparam logic [1:0] MODE_HOLD    = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    function automatic int phase_width(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/sc_phase_decode.sv
// Combinational legality check and phase index decode of the counter value.
// Hold/reserved modes decode with the Johnson interpretation so phase stays meaningful.
module sc_phase_decode
    import shift_counter_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int PW    = phase_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [1:0]       i_mode,
    output logic [PW-1:0]    o_phase,
    output logic             o_legal
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    ZERO_P = {PW{1'b0}};
    localparam logic [PW:0]      TWO_W  = (PW+1)'(2 * WIDTH);

    logic [WIDTH-1:0] w_nq;
    logic             w_therm_lo;
    logic             w_therm_hi;
    logic             w_one_hot;
    logic [PW-1:0]    w_pop;
    logic [PW-1:0]    w_idx;
    logic [PW:0]      w_jphase_hi;

    // A thermometer value plus one (or its complement plus one) is a power of two or zero.
    assign w_nq        = ~i_q;
    assign w_therm_lo  = ((i_q & (i_q + ONE_W)) == ZERO_W);
    assign w_therm_hi  = ((w_nq & (w_nq + ONE_W)) == ZERO_W);
    assign w_one_hot   = (i_q != ZERO_W) && ((i_q & (i_q - ONE_W)) == ZERO_W);
    assign w_jphase_hi = TWO_W - {1'b0, w_pop};

    // Population count and OR-reduced bit index (exact only for one-hot values).
    always_comb begin
        w_pop = ZERO_P;
        w_idx = ZERO_P;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + {{(PW-1){1'b0}}, i_q[i]};
            w_idx = w_idx | ({PW{i_q[i]}} & PW'(i));
        end
    end

    // Mode-dependent legality and phase selection.
    always_comb begin
        o_phase = ZERO_P;
        o_legal = 1'b0;
        if (i_mode == MODE_RING) begin
            o_legal = w_one_hot;
            o_phase = w_one_hot ? w_idx : ZERO_P;
        end else begin
            o_legal = w_therm_lo | w_therm_hi;
            if (!(w_therm_lo | w_therm_hi)) begin
                o_phase = ZERO_P;
            end else if (i_q[WIDTH-1]) begin
                o_phase = w_jphase_hi[PW-1:0];
            end else begin
                o_phase = w_pop;
            end
        end
    end

endmodule

// File: rtl/shift_counter_gen.sv
// Multi-mode Johnson/ring shift counter with parallel load, phase decode,
// registered wrap pulse and sticky illegal-state flag.
module shift_counter_gen
    import shift_counter_pkg::*;
#(
    parameter  int WIDTH        = 8,
    parameter  bit SELF_CORRECT = 1'b1,
    localparam int PW           = phase_width(WIDTH)
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    ZERO_P    = {PW{1'b0}};
    localparam logic [PW-1:0]    LAST_RING = PW'(WIDTH - 1);
    localparam logic [PW-1:0]    LAST_JOHN = PW'(2 * WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_err;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic             w_err_next;
    logic [WIDTH-1:0] w_shift;
    logic [PW-1:0]    w_phase;
    logic [PW-1:0]    w_last;
    logic             w_legal;
    logic             w_is_ring;
    logic             w_active;

    sc_phase_decode #(
        .WIDTH (WIDTH)
    ) u_phase_decode (
        .i_q     (r_q),
        .i_mode  (mode),
        .o_phase (w_phase),
        .o_legal (w_legal)
    );

    assign w_is_ring = (mode == MODE_RING);
    assign w_active  = en & (w_is_ring | (mode == MODE_JOHNSON));
    assign w_last    = w_is_ring ? LAST_RING : LAST_JOHN;

    // Raw shift: ring feeds the outgoing bit back, Johnson feeds its inverse.
    always_comb begin
        w_shift = r_q;
        if (dir) begin
            w_shift = {(w_is_ring ? r_q[0] : ~r_q[0]), r_q[WIDTH-1:1]};
        end else begin
            w_shift = {r_q[WIDTH-2:0], (w_is_ring ? r_q[WIDTH-1] : ~r_q[WIDTH-1])};
        end
    end

    // Next-state selection: load beats stepping; illegal steps flag err and may be corrected.
    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        w_err_next  = r_err;
        if (load) begin
            w_q_next = load_val;
        end else if (w_active) begin
            if (!w_legal) begin
                w_err_next = 1'b1;
                if (SELF_CORRECT) begin
                    w_q_next = w_is_ring ? ONE_W : ZERO_W;
                end else begin
                    w_q_next = w_shift;
                end
            end else begin
                w_q_next    = w_shift;
                w_wrap_next = dir ? (w_phase == ZERO_P) : (w_phase == w_last);
            end
        end else begin
            w_q_next = r_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (r) begin
            r_q    <= ZERO_W;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
            r_err  <= w_err_next;
        end
    end

    assign q     = r_q;
    assign phase = w_phase;
    assign wrap  = r_wrap;
    assign err   = r_err;

endmodule
